// File: rtl/eth_rx_deframer.sv
// rtl/eth_rx_deframer.sv - RMII receive deframer: preamble/SFD hunt, dibit-to-byte assembly, frame length/error reporting
//
// Purpose:
//   Watches the RMII receive dibit stream. It locks onto a run of 01 preamble
//   dibits terminated by an 11 SFD dibit, then packs the following dibits
//   LSB-first into bytes. Each completed byte is strobed out, and a frame
//   summary (length, error) is emitted when carrier drops. A frame that runs
//   past MAX_LEN bytes is cut off and flagged.
//
// Ports:
//   Clk            in   RMII reference clock, one dibit per cycle
//   Rst            in   synchronous active-high reset
//   Crs_Dv         in   RMII carrier sense / data valid
//   Rxd[1:0]       in   RMII receive dibit
//   Eth_Byte[7:0]  out  received byte, holds its value between strobes
//   Eth_Byte_Valid out  one-cycle strobe qualifying Eth_Byte
//   Eth_Pkt_Start  out  marks the first byte strobe of a frame
//   Eth_Pkt_Done   out  one-cycle end-of-frame strobe
//   Eth_Pkt_Len    out  bytes delivered in the frame, held until next Done
//   Eth_Pkt_Err    out  runt / alignment / oversize flag, held until next Done
//   Rx_Busy        out  high whenever the deframer is not idle

module eth_rx_deframer #(
    parameter int PRE_MIN = 8,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Crs_Dv,
    input  logic [1:0]  Rxd,
    output logic [7:0]  Eth_Byte,
    output logic        Eth_Byte_Valid,
    output logic        Eth_Pkt_Start,
    output logic        Eth_Pkt_Done,
    output logic [10:0] Eth_Pkt_Len,
    output logic        Eth_Pkt_Err,
    output logic        Rx_Busy
);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_t;

    localparam logic [4:0]  PRE_MIN_C = 5'(PRE_MIN);
    localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);
    localparam logic [4:0]  PRE_SAT   = 5'd31;

    state_t      state;
    state_t      state_nx;
    logic [4:0]  pre_cnt;
    logic [4:0]  pre_cnt_nx;
    logic [1:0]  phase;
    logic [1:0]  phase_nx;
    logic [10:0] byte_cnt;
    logic [10:0] byte_cnt_nx;
    logic [7:0]  sr;
    logic [7:0]  sr_nx;
    logic [7:0]  sr_shift;

    logic [7:0]  byte_nx;
    logic        valid_nx;
    logic        start_nx;
    logic        done_nx;
    logic [10:0] len_nx;
    logic        err_nx;
    logic        busy_nx;

    // First dibit received lands in the byte's two LSBs after four shifts.
    assign sr_shift = {Rxd, sr[7:2]};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            // Reset parks in DROP so a frame already in flight is ignored
            // until carrier drops and a fresh preamble arrives.
            state          <= DROP;
            pre_cnt        <= 5'd0;
            phase          <= 2'd0;
            byte_cnt       <= 11'd0;
            sr             <= 8'd0;
            Eth_Byte       <= 8'd0;
            Eth_Byte_Valid <= 1'b0;
            Eth_Pkt_Start  <= 1'b0;
            Eth_Pkt_Done   <= 1'b0;
            Eth_Pkt_Len    <= 11'd0;
            Eth_Pkt_Err    <= 1'b0;
            Rx_Busy        <= 1'b1;
        end else begin
            state          <= state_nx;
            pre_cnt        <= pre_cnt_nx;
            phase          <= phase_nx;
            byte_cnt       <= byte_cnt_nx;
            sr             <= sr_nx;
            Eth_Byte       <= byte_nx;
            Eth_Byte_Valid <= valid_nx;
            Eth_Pkt_Start  <= start_nx;
            Eth_Pkt_Done   <= done_nx;
            Eth_Pkt_Len    <= len_nx;
            Eth_Pkt_Err    <= err_nx;
            Rx_Busy        <= busy_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        pre_cnt_nx  = pre_cnt;
        phase_nx    = phase;
        byte_cnt_nx = byte_cnt;
        sr_nx       = sr;
        byte_nx     = Eth_Byte;
        valid_nx    = 1'b0;
        start_nx    = 1'b0;
        done_nx     = 1'b0;
        len_nx      = Eth_Pkt_Len;
        err_nx      = Eth_Pkt_Err;

        case (state)
            IDLE: begin
                if (Crs_Dv && (Rxd == 2'b01)) begin
                    state_nx   = PREAMBLE;
                    pre_cnt_nx = 5'd1;
                end
            end

            PREAMBLE: begin
                if (!Crs_Dv) begin
                    state_nx = IDLE;
                end else if (Rxd == 2'b01) begin
                    if (pre_cnt != PRE_SAT) begin
                        pre_cnt_nx = pre_cnt + 5'd1;
                    end
                end else if ((Rxd == 2'b11) && (pre_cnt >= PRE_MIN_C)) begin
                    state_nx    = DATA;
                    phase_nx    = 2'd0;
                    byte_cnt_nx = 11'd0;
                end else begin
                    // Short preamble or a corrupt dibit: sit out this carrier burst.
                    state_nx = DROP;
                end
            end

            DATA: begin
                if (!Crs_Dv) begin
                    // Any partial byte in sr is simply abandoned here.
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                    len_nx   = byte_cnt;
                    err_nx   = (phase != 2'd0) || (byte_cnt < MIN_LEN_C);
                end else begin
                    sr_nx    = sr_shift;
                    phase_nx = phase + 2'd1;
                    if (phase == 2'd3) begin
                        if (byte_cnt == MAX_LEN_C) begin
                            // Oversize: close the frame at MAX_LEN and swallow
                            // the rest of the burst without further strobes.
                            state_nx = DROP;
                            done_nx  = 1'b1;
                            len_nx   = MAX_LEN_C;
                            err_nx   = 1'b1;
                        end else begin
                            byte_nx     = sr_shift;
                            valid_nx    = 1'b1;
                            start_nx    = (byte_cnt == 11'd0);
                            byte_cnt_nx = byte_cnt + 11'd1;
                        end
                    end
                end
            end

            DROP: begin
                if (!Crs_Dv) begin
                    state_nx = IDLE;
                end
            end

            default: begin
                state_nx = DROP;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_eth_rx_deframer.sv
// tb/tb_eth_rx_deframer.sv - self-checking bench for eth_rx_deframer

module tb_eth_rx_deframer;

    localparam int PRE_MIN = 8;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Crs_Dv;
    logic [1:0]  Rxd;
    logic [7:0]  Eth_Byte;
    logic        Eth_Byte_Valid;
    logic        Eth_Pkt_Start;
    logic        Eth_Pkt_Done;
    logic [10:0] Eth_Pkt_Len;
    logic        Eth_Pkt_Err;
    logic        Rx_Busy;

    always #10 Clk = ~Clk;

    eth_rx_deframer #(
        .PRE_MIN(PRE_MIN),
        .MIN_LEN(MIN_LEN),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Crs_Dv         (Crs_Dv),
        .Rxd            (Rxd),
        .Eth_Byte       (Eth_Byte),
        .Eth_Byte_Valid (Eth_Byte_Valid),
        .Eth_Pkt_Start  (Eth_Pkt_Start),
        .Eth_Pkt_Done   (Eth_Pkt_Done),
        .Eth_Pkt_Len    (Eth_Pkt_Len),
        .Eth_Pkt_Err    (Eth_Pkt_Err),
        .Rx_Busy        (Rx_Busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Captured DUT activity for the current frame
    logic [7:0]  got_bytes[$];
    bit          got_start[$];
    int          got_edge[$];
    int          got_done;
    int          got_len;
    int          got_err;
    int          done_edge;

    // Stimulus payload and reference expectations
    logic [7:0]  tx_bytes[$];
    logic [7:0]  exp_bytes[$];
    int          exp_done;
    int          exp_len;
    int          exp_err;
    bit          exp_ovf;
    int          held_len  = 0;
    int          held_err  = 0;
    int          held_byte = 0;

    typedef struct {
        int         n01;
        logic [1:0] sfd;
        int         nbytes;
        int         extra;
        int         exp_n;
        int         exp_done;
        int         exp_len;
        int         exp_err;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge Clk) begin
        #1;
        if (Eth_Byte_Valid) begin
            got_bytes.push_back(Eth_Byte);
            got_start.push_back(Eth_Pkt_Start);
            got_edge.push_back(cyc);
        end
        if (Eth_Pkt_Done) begin
            got_done++;
            got_len   = int'(Eth_Pkt_Len);
            got_err   = int'(Eth_Pkt_Err);
            done_edge = cyc;
        end
        if (Eth_Byte_Valid || Eth_Pkt_Done) begin
            checks++;
            if (Eth_Byte_Valid && Eth_Pkt_Done) begin
                errors++;
                $display("FAIL valid_done_overlap: got both high at cycle %0d expected exclusive", cyc);
            end
        end
        if (Eth_Pkt_Start) begin
            checks++;
            if (!Eth_Byte_Valid) begin
                errors++;
                $display("FAIL start_without_valid: got start=1 valid=0 at cycle %0d expected valid=1", cyc);
            end
        end
    end

    // Frame-level reference: a frame exists only for >=PRE_MIN preamble
    // dibits closed by 11; every full byte is delivered up to MAX_LEN.
    task automatic model(input int n01, input logic [1:0] sfd, input int extra);
        int total;
        int complete;
        exp_bytes.delete();
        exp_done = 0;
        exp_len  = 0;
        exp_err  = 0;
        exp_ovf  = 1'b0;
        if (sfd == 2'b11 && n01 >= PRE_MIN) begin
            total    = tx_bytes.size() * 4 + extra;
            complete = total / 4;
            exp_done = 1;
            if (complete > MAX_LEN) begin
                for (int i = 0; i < MAX_LEN; i++) exp_bytes.push_back(tx_bytes[i]);
                exp_len = MAX_LEN;
                exp_err = 1;
                exp_ovf = 1'b1;
            end else begin
                for (int i = 0; i < complete; i++) exp_bytes.push_back(tx_bytes[i]);
                exp_len = complete;
                exp_err = ((total % 4) != 0 || complete < MIN_LEN) ? 1 : 0;
            end
        end
    endtask

    task automatic drive(input logic crs, input logic [1:0] d);
        @(negedge Clk);
        Crs_Dv = crs;
        Rxd    = d;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) drive(1'b1, b[2*k +: 2]);
    endtask

    task automatic clear_capture();
        got_bytes.delete();
        got_start.delete();
        got_edge.delete();
        got_done  = 0;
        done_edge = -1;
    endtask

    task automatic run_frame(input int n01, input logic [1:0] sfd, input int extra);
        int sfd_edge;
        int low_edge;
        int bad;
        int n;
        clear_capture();
        model(n01, sfd, extra);
        for (int i = 0; i < n01; i++) drive(1'b1, 2'b01);
        drive(1'b1, sfd);
        sfd_edge = cyc + 1;
        foreach (tx_bytes[i]) send_byte(tx_bytes[i]);
        for (int i = 0; i < extra; i++) drive(1'b1, 2'(i + 1));
        drive(1'b0, 2'b00);
        low_edge = cyc + 1;
        @(posedge Clk);
        #2;
        chk("busy_after_crs_low", int'(Rx_Busy), 0);
        for (int i = 0; i < 4; i++) drive(1'b0, 2'b00);
        @(posedge Clk);
        #2;

        chk("strobe_count", got_bytes.size(), exp_bytes.size());
        n = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
        bad = 0;
        for (int i = 0; i < n; i++) if (got_bytes[i] != exp_bytes[i]) bad++;
        chk("byte_values", bad, 0);
        if (got_bytes.size() > 0) begin
            bad = 0;
            foreach (got_start[i]) if (got_start[i] != (i == 0)) bad++;
            chk("start_flags", bad, 0);
            chk("first_strobe_edge", got_edge[0], sfd_edge + 4);
            bad = 0;
            for (int i = 1; i < got_edge.size(); i++) if (got_edge[i] - got_edge[i-1] != 4) bad++;
            chk("strobe_spacing", bad, 0);
        end
        chk("done_count", got_done, exp_done);
        if (exp_done != 0 && got_done > 0) begin
            chk("done_len", got_len, exp_len);
            chk("done_err", got_err, exp_err);
            chk("done_edge", done_edge, exp_ovf ? sfd_edge + 4 * (MAX_LEN + 1) : low_edge);
        end
        if (exp_done != 0) begin
            held_len = exp_len;
            held_err = exp_err;
        end
        if (exp_bytes.size() > 0) held_byte = int'(exp_bytes[exp_bytes.size() - 1]);
        chk("len_held", int'(Eth_Pkt_Len), held_len);
        chk("err_held", int'(Eth_Pkt_Err), held_err);
        chk("byte_held", int'(Eth_Byte), held_byte);
    endtask

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{31, 2'b11,   64, 0,   64, 1,   64, 0};
        tbl[1]  = '{ 8, 2'b11,   10, 0,   10, 1,   10, 1};
        tbl[2]  = '{ 8, 2'b11,   64, 1,   64, 1,   64, 1};
        tbl[3]  = '{ 4, 2'b11,   64, 0,    0, 0,    0, 0};
        tbl[4]  = '{10, 2'b10,   64, 0,    0, 0,    0, 0};
        tbl[5]  = '{ 8, 2'b11,   64, 0,   64, 1,   64, 0};
        tbl[6]  = '{ 7, 2'b11,   64, 0,    0, 0,    0, 0};
        tbl[7]  = '{12, 2'b00,   64, 0,    0, 0,    0, 0};
        tbl[8]  = '{ 9, 2'b11,   63, 0,   63, 1,   63, 1};
        tbl[9]  = '{ 8, 2'b11,    0, 0,    0, 1,    0, 1};
        tbl[10] = '{ 8, 2'b11,   64, 2,   64, 1,   64, 1};
        tbl[11] = '{ 8, 2'b11, 1518, 0, 1518, 1, 1518, 0};
        tbl[12] = '{ 8, 2'b11, 1520, 0, 1518, 1, 1518, 1};
        tbl[13] = '{ 8, 2'b11, 1519, 3, 1518, 1, 1518, 1};

        Rst    = 1'b1;
        Crs_Dv = 1'b0;
        Rxd    = 2'b00;
        clear_capture();
        repeat (3) @(negedge Clk);
        chk("rst_byte",  int'(Eth_Byte), 0);
        chk("rst_valid", int'(Eth_Byte_Valid), 0);
        chk("rst_start", int'(Eth_Pkt_Start), 0);
        chk("rst_done",  int'(Eth_Pkt_Done), 0);
        chk("rst_len",   int'(Eth_Pkt_Len), 0);
        chk("rst_err",   int'(Eth_Pkt_Err), 0);
        chk("rst_busy",  int'(Rx_Busy), 1);
        Rst = 1'b0;
        @(negedge Clk);
        chk("busy_idle_after_rst", int'(Rx_Busy), 0);

        foreach (tbl[t]) begin
            tx_bytes.delete();
            for (int i = 0; i < tbl[t].nbytes; i++) tx_bytes.push_back(8'(i));
            run_frame(tbl[t].n01, tbl[t].sfd, tbl[t].extra);
            chk($sformatf("tbl%0d_strobes", t), got_bytes.size(), tbl[t].exp_n);
            chk($sformatf("tbl%0d_done", t), got_done, tbl[t].exp_done);
            if (tbl[t].exp_done != 0) begin
                chk($sformatf("tbl%0d_len", t), int'(Eth_Pkt_Len), tbl[t].exp_len);
                chk($sformatf("tbl%0d_err", t), int'(Eth_Pkt_Err), tbl[t].exp_err);
            end
        end

        // Reset in the middle of a frame while carrier stays up
        clear_capture();
        for (int i = 0; i < 8; i++) drive(1'b1, 2'b01);
        drive(1'b1, 2'b11);
        for (int i = 0; i < 20; i++) send_byte(8'(i + 100));
        @(negedge Clk);
        Rst    = 1'b1;
        Crs_Dv = 1'b1;
        Rxd    = 2'b10;
        @(posedge Clk);
        #2;
        chk("midrst_byte",  int'(Eth_Byte), 0);
        chk("midrst_valid", int'(Eth_Byte_Valid), 0);
        chk("midrst_start", int'(Eth_Pkt_Start), 0);
        chk("midrst_done",  int'(Eth_Pkt_Done), 0);
        chk("midrst_len",   int'(Eth_Pkt_Len), 0);
        chk("midrst_err",   int'(Eth_Pkt_Err), 0);
        chk("midrst_busy",  int'(Rx_Busy), 1);
        @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < 50; i++) send_byte(8'(i));
        for (int i = 0; i < 5; i++) drive(1'b0, 2'b00);
        @(posedge Clk);
        #2;
        chk("midrst_strobes", got_bytes.size(), 20);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < got_bytes.size() && i < 20; i++) if (got_bytes[i] != 8'(i + 100)) bad++;
            chk("midrst_bytes", bad, 0);
        end
        chk("midrst_no_done", got_done, 0);
        held_len  = 0;
        held_err  = 0;
        held_byte = 0;
        tx_bytes.delete();
        for (int i = 0; i < 64; i++) tx_bytes.push_back(8'($urandom));
        run_frame(8, 2'b11, 0);
        chk("postrst_len", int'(Eth_Pkt_Len), 64);
        chk("postrst_err", int'(Eth_Pkt_Err), 0);

        // Randomized frames against the reference model
        for (int f = 0; f < 20; f++) begin
            int n01;
            int nb;
            int ex;
            int r;
            logic [1:0] sfd;
            n01 = $urandom_range(1, 40);
            r   = $urandom_range(0, 5);
            sfd = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b11;
            nb  = $urandom_range(0, 120);
            if ($urandom_range(0, 9) == 0) nb = $urandom_range(1510, 1525);
            ex  = $urandom_range(0, 3);
            tx_bytes.delete();
            for (int i = 0; i < nb; i++) tx_bytes.push_back(8'($urandom));
            run_frame(n01, sfd, ex);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
